// File: rtl/dice_roll_arbiter.sv
// Round-robin arbiter/sequencer sharing one dice-roll RNG datapath between NUM_REQ requesters.
// Optional WAIT timeout is compiled in when ROLL_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no roll in flight; grant the next pending requester round-robin
// WAIT  | RNG running for the latched die, waiting for rng_valid
// RESP  | roll/err latched; pulse rsp_valid to the granted requester next edge
module dice_roll_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [4*NUM_REQ-1:0]   req_die,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [4:0]             rsp_roll,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   rng_run,
    output logic [3:0]             rng_die,
    input  logic                   rng_valid,
    input  logic [4:0]             rng_roll
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("dice_roll_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   grant_q;
    logic [3:0]      die_q;
    logic [4:0]      roll_q;
    logic            err_q;

    logic            grant_found;
    logic [GW-1:0]   grant_idx;
    logic [GW-1:0]   cand;
    logic [3:0]      sel_die;

`ifdef ROLL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]   wait_cnt;
`endif

    function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return GW'(s);
    endfunction

    function automatic logic [4:0] face_of(input logic [3:0] code);
        case (code)
            4'd0:    face_of = 5'd4;
            4'd1:    face_of = 5'd6;
            4'd2:    face_of = 5'd8;
            4'd3:    face_of = 5'd10;
            4'd4:    face_of = 5'd12;
            4'd5:    face_of = 5'd20;
            default: face_of = 5'd0;
        endcase
    endfunction

    // Search upward from the slot after the last winner so every pending requester is reached.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = wrap_idx(last_grant, i);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign sel_die = req_die[{grant_idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            last_grant <= GW'(NUM_REQ - 1);
            grant_q    <= '0;
            die_q      <= '0;
            roll_q     <= '0;
            err_q      <= 1'b0;
            rsp_valid  <= '0;
            rsp_roll   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            rng_run    <= 1'b0;
            rng_die    <= '0;
`ifdef ROLL_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            rsp_valid <= '0;
            rsp_roll  <= '0;
            rsp_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        grant_q <= grant_idx;
                        die_q   <= sel_die;
                        busy    <= 1'b1;
                        if (sel_die <= 4'd5) begin
                            state   <= S_WAIT;
                            rng_run <= 1'b1;
                            rng_die <= sel_die;
`ifdef ROLL_TIMEOUT_EN
                            wait_cnt <= CW'(TIMEOUT_CYCLES - 1);
`endif
                        end else begin
                            state  <= S_RESP;
                            roll_q <= '0;
                            err_q  <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (rng_valid) begin
                        state   <= S_RESP;
                        roll_q  <= rng_roll;
                        err_q   <= (rng_roll == 5'd0) || (rng_roll > face_of(die_q));
                        rng_run <= 1'b0;
                        rng_die <= '0;
                    end
`ifdef ROLL_TIMEOUT_EN
                    else if (wait_cnt == '0) begin
                        state   <= S_RESP;
                        roll_q  <= '0;
                        err_q   <= 1'b1;
                        rng_run <= 1'b0;
                        rng_die <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    rsp_valid  <= NUM_REQ'(1) << grant_q;
                    rsp_roll   <= roll_q;
                    rsp_err    <= err_q;
                    last_grant <= grant_q;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    rng_run <= 1'b0;
                    rng_die <= '0;
                end
            endcase
        end
    end

endmodule
